// File: rtl/fetcher_pkg.sv
// Shared types and default sizing for the ping-pong matrix fetcher.
// Optional build macro used by this slice: FETCHER_TRANSPOSE_EN (column streaming).
package fetcher_pkg;

  // Streaming controller states
  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_FEED = 1'b1
  } fetcher_state_e;

  // Default systolic edge length and element width
  localparam int FETCHER_N  = 8;
  localparam int FETCHER_DW = 16;

endpackage

// File: rtl/fetcher_bank.sv
// One N x N matrix store: a single row write port and a row read port.
// With FETCHER_TRANSPOSE_EN defined, a column read port is added as well.
// Storage is deliberately not reset; the owning fetcher tracks validity.
module fetcher_bank
  import fetcher_pkg::*;
#(
  parameter int N  = FETCHER_N,
  parameter int DW = FETCHER_DW,
  parameter int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [N*DW-1:0] wdata,
  input  logic [AW-1:0]   rd_idx,
`ifdef FETCHER_TRANSPOSE_EN
  output logic [N*DW-1:0] rd_col,
`endif
  output logic [N*DW-1:0] rd_row
);

  logic [N*DW-1:0] mem_r [N];

  // Row write port; unwritten rows keep their previous contents
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rd_row = mem_r[rd_idx];

`ifdef FETCHER_TRANSPOSE_EN
  // Column read: element i of the result is element rd_idx of row i
  always_comb begin
    rd_col = '0;
    for (int i = 0; i < N; i++) begin
      rd_col[i*DW +: DW] = mem_r[i][rd_idx*DW +: DW];
    end
  end
`endif

endmodule

// File: rtl/pingpong_fetcher.sv
// Double-buffered matrix fetcher: a bus side fills one bank row by row while
// the other bank streams one row (or column) per cycle to the skew stage.
// Optional build macro: FETCHER_TRANSPOSE_EN adds the 'transpose' input.
module pingpong_fetcher
  import fetcher_pkg::*;
#(
  parameter int N  = FETCHER_N,
  parameter int DW = FETCHER_DW,
  parameter int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cs,
  input  logic            wvalid,
  output logic            wready,
  input  logic [N*DW-1:0] wdata,
  input  logic [AW-1:0]   waddr,
  input  logic            wlast,
  input  logic            feed,
`ifdef FETCHER_TRANSPOSE_EN
  input  logic            transpose,
`endif
  output logic            feed_ready,
  output logic [N*DW-1:0] data_out,
  output logic            data_valid,
  output logic            data_last
);

  fetcher_state_e  state_r, next_state_s;
  logic            wb_r, rb_r;
  logic [1:0]      full_r, full_set_s, full_clr_s;
  logic [AW-1:0]   cnt_r, next_cnt_s, rd_idx_s;
  logic            load_s, done_s, rd_bank_s;
  logic            feed_ready_s, feed_go_s, wready_s, write_go_s;
  logic [N*DW-1:0] row0_s, row1_s, rd_data_s;
  logic [N*DW-1:0] data_out_r;
  logic            data_valid_r, data_last_r;

  assign wready_s   = !full_r[wb_r];
  assign write_go_s = cs && wvalid && wready_s;
  assign wready     = wready_s;
  assign feed_ready = feed_ready_s;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign data_last  = data_last_r;

  // Next-state, row sequencing and read-bank selection for the streamer
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    load_s       = 1'b0;
    done_s       = 1'b0;
    rd_bank_s    = rb_r;
    rd_idx_s     = cnt_r + AW'(1);
    // On the final row the next matrix comes from the opposite bank
    if (state_r == FETCH_IDLE) begin
      feed_ready_s = full_r[rb_r];
    end else begin
      feed_ready_s = data_last_r && full_r[~rb_r];
    end
    feed_go_s = feed && feed_ready_s;
    case (state_r)
      FETCH_IDLE: begin
        if (feed_go_s) begin
          next_state_s = FETCH_FEED;
          load_s       = 1'b1;
          next_cnt_s   = '0;
          rd_idx_s     = '0;
        end else begin
          next_state_s = FETCH_IDLE;
        end
      end
      FETCH_FEED: begin
        if (data_last_r) begin
          done_s = 1'b1;
          if (feed_go_s) begin
            load_s     = 1'b1;
            next_cnt_s = '0;
            rd_idx_s   = '0;
            rd_bank_s  = ~rb_r;
          end else begin
            next_state_s = FETCH_IDLE;
          end
        end else begin
          load_s     = 1'b1;
          next_cnt_s = cnt_r + AW'(1);
        end
      end
      default: begin
        next_state_s = FETCH_IDLE;
      end
    endcase
  end

`ifdef FETCHER_TRANSPOSE_EN
  logic [N*DW-1:0] col0_s, col1_s;
  logic            transpose_r, tr_sel_s;

  // Orientation is captured once per matrix, at feed acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      transpose_r <= 1'b0;
    end else if (feed_go_s) begin
      transpose_r <= transpose;
    end
  end

  // Select bank and orientation of the word loaded into data_out
  always_comb begin
    tr_sel_s = (next_cnt_s == '0) ? transpose : transpose_r;
    if (tr_sel_s) begin
      rd_data_s = rd_bank_s ? col1_s : col0_s;
    end else begin
      rd_data_s = rd_bank_s ? row1_s : row0_s;
    end
  end
`else
  // Select the bank whose row is loaded into data_out
  always_comb begin
    if (rd_bank_s) begin
      rd_data_s = row1_s;
    end else begin
      rd_data_s = row0_s;
    end
  end
`endif

  // Controller state, row counter and read pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH_IDLE;
      cnt_r   <= '0;
      rb_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      if (done_s) begin
        rb_r <= ~rb_r;
      end
    end
  end

  // A completed fill marks its bank full; a completed stream frees its bank
  always_comb begin
    full_set_s = {(write_go_s && wlast && wb_r), (write_go_s && wlast && !wb_r)};
    full_clr_s = {(done_s && rb_r), (done_s && !rb_r)};
  end

  // Write pointer and bank-full flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_r   <= 1'b0;
      full_r <= 2'b00;
    end else begin
      full_r <= (full_r | full_set_s) & ~full_clr_s;
      if (write_go_s && wlast) begin
        wb_r <= ~wb_r;
      end
    end
  end

  // Registered stream outputs; data_out is zero whenever nothing is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
      data_last_r  <= 1'b0;
    end else begin
      data_out_r   <= load_s ? rd_data_s : '0;
      data_valid_r <= load_s;
      data_last_r  <= load_s && (next_cnt_s == AW'(N - 1));
    end
  end

  fetcher_bank #(.N(N), .DW(DW), .AW(AW)) u_bank0 (
    .clk    (clk),
    .we     (write_go_s && !wb_r),
    .waddr  (waddr),
    .wdata  (wdata),
    .rd_idx (rd_idx_s),
`ifdef FETCHER_TRANSPOSE_EN
    .rd_col (col0_s),
`endif
    .rd_row (row0_s)
  );

  fetcher_bank #(.N(N), .DW(DW), .AW(AW)) u_bank1 (
    .clk    (clk),
    .we     (write_go_s && wb_r),
    .waddr  (waddr),
    .wdata  (wdata),
    .rd_idx (rd_idx_s),
`ifdef FETCHER_TRANSPOSE_EN
    .rd_col (col1_s),
`endif
    .rd_row (row1_s)
  );

endmodule

// File: tb/tb_pingpong_fetcher.sv
// Randomised bench for pingpong_fetcher (N=4, DW=16) with a queue-based
// reference model; directed phases pin the model with literal expectations.
module tb_pingpong_fetcher;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int W  = N * DW;
`ifdef FETCHER_TRANSPOSE_EN
  localparam bit TR_EN = 1'b1;
`else
  localparam bit TR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, cs, wvalid, wlast, feed;
  logic [W-1:0]  wdata;
  logic [AW-1:0] waddr;
  logic          wready, feed_ready, data_valid, data_last;
  logic [W-1:0]  data_out;
`ifdef FETCHER_TRANSPOSE_EN
  logic          transpose;
`endif

  always #5 clk = ~clk;

  pingpong_fetcher #(.N(N), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs         (cs),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .waddr      (waddr),
    .wlast      (wlast),
    .feed       (feed),
`ifdef FETCHER_TRANSPOSE_EN
    .transpose  (transpose),
`endif
    .feed_ready (feed_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_last  (data_last)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference model: bank contents, full flags, pointers, output queue
  typedef struct {
    logic [W-1:0] d;
    bit           last;
    int           bank;
  } item_t;

  logic [DW-1:0] mm [2][N][N];
  bit            mfull [2];
  int            mwb, mnb;
  item_t         q [$];
  bit            cur_valid, cur_last;
  logic [W-1:0]  cur_data;
  int            cur_bank;

  task automatic chk_vec(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  function automatic bit m_wready();
    return !mfull[mwb];
  endfunction

  function automatic bit m_feed_ready();
    return (q.size() == 0) && (!cur_valid || cur_last) && mfull[mnb];
  endfunction

  function automatic logic [W-1:0] make_row(input int base);
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  task automatic model_reset();
    mfull[0] = 1'b0; mfull[1] = 1'b0;
    mwb = 0; mnb = 0;
    q.delete();
    cur_valid = 1'b0; cur_last = 1'b0; cur_data = '0; cur_bank = 0;
  endtask

  // One clock: compare outputs to the model, drive inputs, advance the model
  task automatic step(input bit s_cs, input bit s_wv, input bit s_wl, input int s_wa,
                      input logic [W-1:0] s_wd, input bit s_feed, input bit s_tr);
    bit    wr_ok, fd_ok, tr_eff;
    item_t it;
    chk_bit("data_valid", data_valid, cur_valid);
    chk_bit("data_last", data_last, cur_valid && cur_last);
    chk_vec("data_out", data_out, cur_valid ? cur_data : '0);
    chk_bit("wready", wready, m_wready());
    chk_bit("feed_ready", feed_ready, m_feed_ready());
    cs = s_cs; wvalid = s_wv; wlast = s_wl; waddr = AW'(s_wa); wdata = s_wd; feed = s_feed;
`ifdef FETCHER_TRANSPOSE_EN
    transpose = s_tr;
`endif
    tr_eff = s_tr & TR_EN;
    @(posedge clk);
    wr_ok = s_cs && s_wv && m_wready();
    fd_ok = s_feed && m_feed_ready();
    if (fd_ok) begin
      for (int k = 0; k < N; k++) begin
        for (int i = 0; i < N; i++)
          it.d[i*DW +: DW] = tr_eff ? mm[mnb][i][k] : mm[mnb][k][i];
        it.last = (k == N - 1);
        it.bank = mnb;
        q.push_back(it);
      end
      mnb ^= 1;
    end
    if (cur_valid && cur_last) mfull[cur_bank] = 1'b0;
    if (wr_ok) begin
      for (int i = 0; i < N; i++) mm[mwb][s_wa][i] = s_wd[i*DW +: DW];
      if (s_wl) begin
        mfull[mwb] = 1'b1;
        mwb ^= 1;
      end
    end
    if (q.size() > 0) begin
      it = q.pop_front();
      cur_valid = 1'b1; cur_last = it.last; cur_data = it.d; cur_bank = it.bank;
    end else begin
      cur_valid = 1'b0; cur_last = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill_pattern(input int base);
    for (int r = 0; r < N; r++) step(1'b1, 1'b1, r == N - 1, r, make_row(base + r * N), 1'b0, 1'b0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++) step(1'b1, 1'b1, r == N - 1, r, {$urandom, $urandom}, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cs = 1'b0; wvalid = 1'b0; wlast = 1'b0; feed = 1'b0;
    waddr = '0; wdata = '0;
`ifdef FETCHER_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rows [N];
    logic [N-1:0] lastmask;
    bit           vseen [8];
    bit           wr_seen [8];
    int           nvalid;

    do_reset();
    chk_bit("rst_wready", wready, 1'b1);
    chk_bit("rst_feed_ready", feed_ready, 1'b0);
    chk_bit("rst_data_valid", data_valid, 1'b0);

    // Feed with no full bank: nothing streams
    nvalid = 0;
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
      nvalid += int'(data_valid);
    end
    chk_vec("empty_feed_valids", W'(nvalid), W'(0));

    // Single matrix, row r element i = r*4+i
    fill_pattern(0);
    chk_bit("filled_feed_ready", feed_ready, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) begin
      rows[k] = data_out;
      lastmask[k] = data_last;
      idle(1);
    end
    chk_vec("lit_row0", rows[0], 64'h0003_0002_0001_0000);
    chk_vec("lit_row3", rows[3], 64'h000F_000E_000D_000C);
    chk_vec("lit_last_mask", W'(lastmask), W'(4'b1000));
    idle(2);

    // Both banks full, back-to-back streams
    fill_random();
    fill_random();
    chk_bit("both_full_wready", wready, 1'b0);
    for (int j = 0; j < 8; j++) begin
      step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
      vseen[j] = data_valid;
      wr_seen[j] = wready;
    end
    nvalid = 0;
    for (int j = 0; j < 8; j++) nvalid += int'(vseen[j]);
    chk_vec("b2b_valid_cycles", W'(nvalid), W'(8));
    chk_bit("wready_during_a_last", wr_seen[3], 1'b0);
    chk_bit("wready_after_a_last", wr_seen[4], 1'b1);
    idle(3);

    // Ignored writes: cs low, and while both banks are full
    step(1'b0, 1'b1, 1'b0, 1, {$urandom, $urandom}, 1'b0, 1'b0);
    fill_pattern(100);
    step(1'b0, 1'b1, 1'b1, 2, {$urandom, $urandom}, 1'b0, 1'b0);
    fill_pattern(200);
    chk_bit("full_wready", wready, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, {$urandom, $urandom}, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 3, {$urandom, $urandom}, 1'b0, 1'b0);
    for (int j = 0; j < 12; j++) step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);

    // Random traffic against the model
    for (int j = 0; j < 1500; j++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, N - 1), {$urandom, $urandom}, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1);
    end

    // Reset in the middle of a stream
    do_reset();
    fill_random();
    step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);
    idle(2);
    chk_bit("pre_reset_valid", data_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_bit("reset_async_valid", data_valid, 1'b0);
    chk_bit("reset_feed_ready", feed_ready, 1'b0);
    chk_vec("reset_data_out", data_out, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    chk_bit("post_reset_wready", wready, 1'b1);
    chk_bit("post_reset_feed_ready", feed_ready, 1'b0);
    @(negedge clk);
    for (int j = 0; j < 6; j++) step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0);

`ifdef FETCHER_TRANSPOSE_EN
    // Transposed streaming: cycle k element i = i*4+k
    fill_pattern(0);
    step(1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b1);
    chk_vec("lit_col0", data_out, 64'h000C_0008_0004_0000);
    idle(1);
    chk_vec("lit_col1", data_out, 64'h000D_0009_0005_0001);
    idle(4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/pingpong_fetcher.md
PINGPONG_FETCHER -- requirements
Module: pingpong_fetcher

Interface
REQ-001 SHALL have parameter N, default 8: systolic array edge length, rows per matrix and elements per row.
REQ-002 SHALL have parameter DW, default 16: element width in bits.
REQ-003 SHALL have derived parameter AW = $clog2(N): row address width.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 cs  input  1  bus chip select for this block.
REQ-007 wvalid  input  1  write row valid.
REQ-008 wready  output  1  write bank can accept a row.
REQ-009 wdata  input  N*DW  one matrix row; element i at bits [i*DW +: DW].
REQ-010 waddr  input  AW  row index within write bank.
REQ-011 wlast  input  1  this write completes the matrix.
REQ-012 feed  input  1  request to stream one matrix to skew stage.
REQ-013 feed_ready  output  1  a full bank is available to stream.
REQ-014 data_out  output  N*DW  streamed row/column, registered.
REQ-015 data_valid  output  1  data_out valid this cycle.
REQ-016 data_last  output  1  final row/column of current matrix.

Function
REQ-017 SHALL hold two N x N banks; write pointer wb, read pointer rb, full flag per bank.
REQ-018 wready SHALL equal !full[wb], combinationally.
REQ-019 Write accepted when cs && wvalid && wready: row waddr of bank wb <= wdata; other rows unchanged.
REQ-020 Accepted write with wlast SHALL set full[wb] and toggle wb; wvalid without cs, or while wready=0, SHALL have no effect.
REQ-021 States IDLE, FEED; feed_ready SHALL be full[rb] && (IDLE || data_last cycle).
REQ-022 feed && feed_ready accepted at cycle T: rows 0..N-1 of bank rb appear on data_out at T+1..T+N, data_valid=1, data_last=1 at T+N only.
REQ-023 On data_last cycle: full[rb] cleared, rb toggled; bank writable (wready reflects it) from next cycle.
REQ-024 feed accepted on a data_last cycle (other bank full) SHALL stream next matrix back-to-back with no bubble; else FEED->IDLE.
REQ-025 feed while feed_ready=0 SHALL be ignored, not queued.
REQ-026 Writes to bank wb SHALL proceed concurrently with streaming from bank rb.
REQ-027 Both banks full: wready=0 until a stream completes.
REQ-028 Row counter SHALL wrap N-1 -> 0 only via completion; data_out SHALL be 0 whenever data_valid=0.

Reset
REQ-029 Reset SHALL force IDLE, wb=rb=0, both full flags 0, row counter 0, data_out 0, data_valid 0, data_last 0; hence wready=1, feed_ready=0.
REQ-030 Bank storage SHALL NOT be reset; reset mid-stream or mid-fill SHALL discard both matrices.

Configuration
REQ-031 Macro FETCHER_TRANSPOSE_EN defined: extra input transpose (1 bit), sampled at feed acceptance; when 1, cycle k emits column k (element i = bank[i][k]); data_last/timing unchanged.
REQ-032 Macro undefined: transpose port absent; row order only.

Structure
REQ-033 Package fetcher_pkg SHALL hold fetcher_state_e {FETCH_IDLE, FETCH_FEED} and default N, DW constants.
REQ-034 Sub-module fetcher_bank SHALL implement one N x N store with one row write port and one row (and, with FETCHER_TRANSPOSE_EN, column) read port; instantiated twice.

Verification
REQ-035 After reset: wready=1, feed_ready=0, data_valid=0; feed=1 -> no data_valid for 10 cycles.
REQ-036 N=4: write rows 0..3 (row r elements = r*4+i), wlast on row 3 -> feed_ready=1; feed at T -> rows 0..3 at T+1..T+4, data_last at T+4 only.
REQ-037 Fill both banks (A, B) -> wready=0; feed, and feed again at A's data_last -> 8 consecutive valid cycles A then B; wready=1 the cycle after A's last.
REQ-038 Writes with cs=0, or wready=0, -> bank contents unchanged on later stream.
REQ-039 rst_n low at mid-stream row 2 -> data_valid=0 immediately, feed_ready=0, wready=1 after release.
REQ-040 FETCHER_TRANSPOSE_EN, transpose=1, matrix m[r][i]=r*4+i -> cycle k outputs element i = i*4+k.
